clk_enable_gen: RTL

CLK_ENABLE_GEN -- requirements
Module: clk_enable_gen

---
 rtl/clk_enable_pkg.sv | 18 +
 rtl/clk_enable_gen_if.sv | 34 +++
 rtl/clk_enable_chan.sv | 67 ++++++
 rtl/clk_enable_gen.sv | 64 ++++++
 4 files changed

// File: rtl/clk_enable_pkg.sv
// Shared defaults and helpers for the clock-enable generator.
package clk_enable_pkg;

  localparam int CNT_W_DEF       = 27;
  localparam int DIV_DEFAULT_DEF = 100000000;

  // Result of validating one divisor write on the cfg bus.
  typedef struct packed {
    logic div_ok;  // divisor is non-zero
    logic ch_ok;   // channel index addresses an existing channel
  } cfg_chk_t;

  // Width of the cfg_ch field: clog2(num_ch), never narrower than one bit.
  function automatic int ch_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/clk_enable_gen_if.sv
// Control/status bundle of the clock-enable generator.
//
// Handshake: cfg_wr is a single-cycle write strobe with no ready/backpressure.
// A write is accepted or rejected on the edge where cfg_wr=1; a rejected write
// (cfg_div == 0 or cfg_ch out of range) is reported by a one-cycle cfg_err
// pulse in the following cycle. sync is a level sampled on every edge.
interface clk_enable_gen_if
  import clk_enable_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int CH_W   = ch_w(NUM_CH)
) ();

  logic [NUM_CH-1:0] ch_en;
  logic              sync;
  logic              cfg_wr;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_div;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] sq;
  logic              cfg_err;

  modport master (
    output ch_en, sync, cfg_wr, cfg_ch, cfg_div,
    input  tick, sq, cfg_err
  );

  modport slave (
    input  ch_en, sync, cfg_wr, cfg_ch, cfg_div,
    output tick, sq, cfg_err
  );

endinterface

// File: rtl/clk_enable_chan.sv
// One divider channel: counts enabled cycles, emits a one-cycle tick every
// div_act cycles and a square wave toggling on each tick. New divisors wait
// in a shadow register until the next wrap or a sync.
module clk_enable_chan #(
  parameter int CNT_W       = 27,
  parameter int DIV_DEFAULT = 100000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
  output logic             tick,
  output logic             sq
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_DEFAULT);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div_act;
  logic [CNT_W-1:0] div_shd;
  logic [CNT_W-1:0] div_shd_nxt;
  logic             wrap;

  // A write lands in the shadow first so a same-edge sync picks it up.
  always_comb begin
    div_shd_nxt = div_shd;
    if (wr) div_shd_nxt = wr_div;
  end

  // Last count of the period; div_act is never 0 so this cannot underflow.
  assign wrap = (cnt == (div_act - ONE));

  // Counter, tick, square wave and divisor registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      tick    <= 1'b0;
      sq      <= 1'b0;
      div_act <= DIV_RST;
      div_shd <= DIV_RST;
    end else begin
      div_shd <= div_shd_nxt;
      if (sync) begin
        cnt     <= '0;
        tick    <= 1'b0;
        sq      <= 1'b0;
        div_act <= div_shd_nxt;
      end else if (en) begin
        if (wrap) begin
          cnt     <= '0;
          tick    <= 1'b1;
          sq      <= ~sq;
          div_act <= div_shd;
        end else begin
          cnt  <= cnt + ONE;
          tick <= 1'b0;
        end
      end else begin
        tick <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clk_enable_gen.sv
// Multi-channel clock-enable generator: decodes divisor writes, flags
// rejected writes and instantiates one divider per channel.
module clk_enable_gen
  import clk_enable_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DIV_DEFAULT = DIV_DEFAULT_DEF
) (
  input logic             clk,
  input logic             rst,
  clk_enable_gen_if.slave bus
);

  cfg_chk_t          chk;
  logic [31:0]       ch_ext;
  logic [NUM_CH-1:0] wr_hit;
  logic [NUM_CH-1:0] tick_v;
  logic [NUM_CH-1:0] sq_v;
  logic              cfg_err_q;

  assign ch_ext = 32'(bus.cfg_ch);

  // Validate the write: divisor must be non-zero and channel must exist.
  always_comb begin
    chk.div_ok = (bus.cfg_div != '0);
    chk.ch_ok  = (ch_ext < 32'(NUM_CH));
  end

  // One-hot write select; only accepted writes reach a channel.
  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_hit[i] = bus.cfg_wr && chk.div_ok && chk.ch_ok && (ch_ext == 32'(i));
    end
  end

  // Registered one-cycle pulse for every rejected write.
  always_ff @(posedge clk) begin
    if (rst) cfg_err_q <= 1'b0;
    else     cfg_err_q <= bus.cfg_wr && !(chk.div_ok && chk.ch_ok);
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    clk_enable_chan #(
      .CNT_W       (CNT_W),
      .DIV_DEFAULT (DIV_DEFAULT)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .en     (bus.ch_en[g]),
      .sync   (bus.sync),
      .wr     (wr_hit[g]),
      .wr_div (bus.cfg_div),
      .tick   (tick_v[g]),
      .sq     (sq_v[g])
    );
  end

  assign bus.tick    = tick_v;
  assign bus.sq      = sq_v;
  assign bus.cfg_err = cfg_err_q;

endmodule
